// File: rtl/alu_exec_unit.sv
// ALU execution unit: in-order issue queue feeding a single-cycle integer datapath
// that broadcasts one result per cycle on the ALU CDB lane.
module alu_exec_unit #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _stall,
    input  logic        _alu_ready,
    input  logic [4:0]  _alu_type,
    input  logic [4:0]  _alu_rob_id,
    input  logic [31:0] _alu_r1,
    input  logic [31:0] _alu_r2,
    input  logic [31:0] _alu_imm,
    output logic        _alu_full,
    output logic        _cdb_ready,
    output logic [4:0]  _cdb_rob_id,
    output logic [31:0] _cdb_value
);

    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_HIGH = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [4:0]       type_mem_r [DEPTH];
    logic [4:0]       rob_mem_r  [DEPTH];
    logic [31:0]      r1_mem_r   [DEPTH];
    logic [31:0]      r2_mem_r   [DEPTH];
    logic [31:0]      imm_mem_r  [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic             push_s;
    logic             pop_s;
    logic [31:0]      result_s;

    // Integer datapath; B comes from imm only for the I-form arithmetic codes.
    function automatic logic [31:0] alu_result(input logic [4:0]  op,
                                               input logic [31:0] a,
                                               input logic [31:0] r2,
                                               input logic [31:0] imm);
        logic [31:0] b;
        logic [4:0]  sh;
        b  = ((op >= 5'd10) && (op <= 5'd18)) ? imm : r2;
        sh = b[4:0];
        case (op)
            5'd0,  5'd10: alu_result = a + b;
            5'd1:         alu_result = a - b;
            5'd2,  5'd11: alu_result = a & b;
            5'd3,  5'd12: alu_result = a | b;
            5'd4,  5'd13: alu_result = a ^ b;
            5'd5,  5'd14: alu_result = a << sh;
            5'd6,  5'd15: alu_result = a >> sh;
            5'd7,  5'd16: alu_result = $signed(a) >>> sh;
            5'd8,  5'd17: alu_result = {31'd0, ($signed(a) < $signed(b))};
            5'd9,  5'd18: alu_result = {31'd0, (a < b)};
            5'd19:        alu_result = imm;
            5'd20:        alu_result = {31'd0, (a == b)};
            5'd21:        alu_result = {31'd0, (a != b)};
            5'd22:        alu_result = {31'd0, ($signed(a) < $signed(b))};
            5'd23:        alu_result = {31'd0, ($signed(a) >= $signed(b))};
            5'd24:        alu_result = {31'd0, (a < b)};
            5'd25:        alu_result = {31'd0, (a >= b)};
            default:      alu_result = 32'd0;
        endcase
    endfunction

    // Queue handshakes; a full queue still accepts when the head leaves on the same edge.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (rst_in && rdy_in && !_clear) begin
            pop_s  = !_stall && (count_r != CNT_ZERO);
            push_s = _alu_ready && ((count_r != CNT_MAX) || pop_s);
        end else begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end
    end

    // Result for the entry currently at the head.
    always_comb begin
        result_s = alu_result(type_mem_r[head_r], r1_mem_r[head_r],
                              r2_mem_r[head_r], imm_mem_r[head_r]);
    end

    assign _alu_full = (count_r >= CNT_HIGH);

    // Queue payload storage, written only on accepted issue.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            type_mem_r[tail_r] <= _alu_type;
            rob_mem_r[tail_r]  <= _alu_rob_id;
            r1_mem_r[tail_r]   <= _alu_r1;
            r2_mem_r[tail_r]   <= _alu_r2;
            imm_mem_r[tail_r]  <= _alu_imm;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else if (!rdy_in) begin
            head_r  <= head_r;
            tail_r  <= tail_r;
            count_r <= count_r;
        end else if (_clear) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // CDB broadcast register; tag and value hold between pulses.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            _cdb_ready  <= 1'b0;
            _cdb_rob_id <= 5'd0;
            _cdb_value  <= 32'd0;
        end else if (!rdy_in) begin
            _cdb_ready  <= _cdb_ready;
        end else if (pop_s) begin
            _cdb_ready  <= 1'b1;
            _cdb_rob_id <= rob_mem_r[head_r];
            _cdb_value  <= result_s;
        end else begin
            _cdb_ready  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against a queue-based reference model.
module tb_alu_exec_unit;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, _clear, _stall, _alu_ready;
    logic [4:0]  _alu_type, _alu_rob_id;
    logic [31:0] _alu_r1, _alu_r2, _alu_imm;
    logic        _alu_full, _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;

    alu_exec_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear), ._stall(_stall),
        ._alu_ready(_alu_ready), ._alu_type(_alu_type), ._alu_rob_id(_alu_rob_id),
        ._alu_r1(_alu_r1), ._alu_r2(_alu_r2), ._alu_imm(_alu_imm),
        ._alu_full(_alu_full), ._cdb_ready(_cdb_ready), ._cdb_rob_id(_cdb_rob_id),
        ._cdb_value(_cdb_value)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  typ;
        logic [4:0]  rob;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
    } op_t;

    op_t         q[$];
    logic        exp_rdy;
    logic [4:0]  exp_id;
    logic [31:0] exp_val;
    logic        exp_full;
    int          vectors = 0;
    int          miscompares = 0;
    int          max_occ = 0;
    int          imm_map [9] = '{0, 2, 3, 4, 5, 6, 7, 8, 9};

    // Reference semantics from the opcode table: I-forms map onto their register twins.
    function automatic logic [31:0] ref_alu(input op_t o);
        int          base;
        logic [31:0] a, b, m;
        longint      sa, sb, ua, ub;
        a = o.r1;
        if (o.typ >= 10 && o.typ <= 18) begin
            base = imm_map[o.typ - 10];
            b = o.imm;
        end else begin
            base = int'(o.typ);
            b = o.r2;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        m  = 32'hFFFF_FFFF >> b[4:0];
        case (base)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << b[4:0];
            6:  return a >> b[4:0];
            7:  return (a >> b[4:0]) | (a[31] ? ~m : 32'd0);
            8:  return (sa < sb) ? 32'd1 : 32'd0;
            9:  return (ua < ub) ? 32'd1 : 32'd0;
            19: return o.imm;
            20: return (a == b) ? 32'd1 : 32'd0;
            21: return (a != b) ? 32'd1 : 32'd0;
            22: return (sa < sb) ? 32'd1 : 32'd0;
            23: return (sa >= sb) ? 32'd1 : 32'd0;
            24: return (ua < ub) ? 32'd1 : 32'd0;
            25: return (ua >= ub) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge: advance the reference model with the inputs present at the edge.
    task automatic tick();
        op_t inc, o;
        bit  pop;
        @(posedge clk_in);
        if (!rst_in) begin
            q.delete();
            exp_rdy = 1'b0; exp_id = 5'd0; exp_val = 32'd0;
        end else if (!rdy_in) begin
            pop = 1'b0;
        end else if (_clear) begin
            q.delete();
            exp_rdy = 1'b0;
        end else begin
            pop = !_stall && (q.size() > 0);
            if (_alu_ready && q.size() == DEPTH && !pop) begin
                $display("FAIL issue_into_full: occupancy=%0d, required below %0d", q.size(), DEPTH);
                miscompares++;
            end
            if (pop) begin
                o = q.pop_front();
                exp_rdy = 1'b1; exp_id = o.rob; exp_val = ref_alu(o);
            end else begin
                exp_rdy = 1'b0;
            end
            if (_alu_ready && q.size() < DEPTH) begin
                inc.typ = _alu_type; inc.rob = _alu_rob_id;
                inc.r1 = _alu_r1; inc.r2 = _alu_r2; inc.imm = _alu_imm;
                q.push_back(inc);
            end
            if (q.size() > max_occ) max_occ = q.size();
        end
        exp_full = (q.size() >= DEPTH - 1);
        #1;
    endtask

    task automatic issue(input logic [4:0] t, input logic [4:0] r, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] i);
        _alu_ready = 1'b1; _alu_type = t; _alu_rob_id = r;
        _alu_r1 = a; _alu_r2 = b; _alu_imm = i;
    endtask

    task automatic issue_rand(input logic [4:0] r);
        issue(5'($urandom_range(31, 0)), r, $urandom, $urandom, $urandom);
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; _clear = 1'b0; _stall = 1'b0; _alu_ready = 1'b0;
        issue(5'd0, 5'd0, 32'd0, 32'd0, 32'd0); _alu_ready = 1'b0;
        tick(); tick();
        vectors++;
        if (_cdb_ready !== 1'b0 || _cdb_rob_id !== 5'd0 || _cdb_value !== 32'd0 || _alu_full !== 1'b0) begin
            $display("FAIL reset: rdy=%0b rob=%0d val=%h full=%0b, required all zero",
                     _cdb_ready, _cdb_rob_id, _cdb_value, _alu_full);
            miscompares++;
        end
        rst_in = 1'b1;
    endtask

    task automatic test_add_latency();
        issue(5'd0, 5'd3, 32'd5, 32'd7, 32'd0);
        tick();
        _alu_ready = 1'b0;
        vectors++;
        if (_cdb_ready !== 1'b0) begin
            $display("FAIL add_early: rdy=%0b, required 0", _cdb_ready); miscompares++;
        end
        tick();
        vectors++;
        if (_cdb_ready !== 1'b1 || _cdb_rob_id !== 5'd3 || _cdb_value !== 32'd12) begin
            $display("FAIL add_result: rdy=%0b rob=%0d val=%h, required 1 3 0000000c",
                     _cdb_ready, _cdb_rob_id, _cdb_value);
            miscompares++;
        end
        tick();
        vectors++;
        if (_cdb_ready !== 1'b0) begin
            $display("FAIL add_pulse_width: rdy=%0b, required 0", _cdb_ready); miscompares++;
        end
    endtask

    task automatic test_directed_ops();
        logic [4:0]  t [5] = '{5'd1, 5'd7, 5'd9, 5'd8, 5'd23};
        logic [31:0] a [5] = '{32'd0, 32'h8000_0000, 32'd1, 32'd1, 32'hFFFF_FFFF};
        logic [31:0] b [5] = '{32'd1, 32'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] e [5] = '{32'hFFFF_FFFF, 32'hC000_0000, 32'd1, 32'd0, 32'd0};
        for (int c = 0; c < 7; c++) begin
            if (c < 5) issue(t[c], 5'(8 + c), a[c], b[c], 32'h1234_5678);
            else _alu_ready = 1'b0;
            tick();
            vectors++;
            if (_cdb_ready !== exp_rdy || _cdb_rob_id !== exp_id || _cdb_value !== exp_val || _alu_full !== exp_full) begin
                $display("FAIL ops_model: rdy=%0b rob=%0d val=%h full=%0b, required %0b %0d %h %0b",
                         _cdb_ready, _cdb_rob_id, _cdb_value, _alu_full, exp_rdy, exp_id, exp_val, exp_full);
                miscompares++;
            end
            if (c >= 1 && c <= 5) begin
                vectors++;
                if (_cdb_ready !== 1'b1 || _cdb_rob_id !== 5'(7 + c) || _cdb_value !== e[c-1]) begin
                    $display("FAIL ops_const[%0d]: rdy=%0b rob=%0d val=%h, required 1 %0d %h",
                             c - 1, _cdb_ready, _cdb_rob_id, _cdb_value, 7 + c, e[c-1]);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_stall();
        _stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue_rand(5'(i + 1));
            tick();
            vectors++;
            if (_cdb_ready !== 1'b0 || _alu_full !== (i == 2)) begin
                $display("FAIL stall_fill[%0d]: rdy=%0b full=%0b, required 0 %0b", i, _cdb_ready, _alu_full, i == 2);
                miscompares++;
            end
        end
        _stall = 1'b0; _alu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (_cdb_ready !== 1'b1 || _cdb_rob_id !== 5'(i + 1) || _cdb_value !== exp_val || _alu_full !== 1'b0) begin
                $display("FAIL stall_drain[%0d]: rdy=%0b rob=%0d val=%h full=%0b, required 1 %0d %h 0",
                         i, _cdb_ready, _cdb_rob_id, _cdb_value, _alu_full, i + 1, exp_val);
                miscompares++;
            end
        end
        tick();
        vectors++;
        if (_cdb_ready !== 1'b0) begin
            $display("FAIL stall_idle: rdy=%0b, required 0", _cdb_ready); miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        max_occ = 0;
        for (int c = 0; c < 11; c++) begin
            if (c < 10) issue_rand(5'(c + 16));
            else _alu_ready = 1'b0;
            tick();
            pulses += int'(_cdb_ready);
            vectors++;
            if (_cdb_ready !== exp_rdy || _cdb_rob_id !== exp_id || _cdb_value !== exp_val || _alu_full !== 1'b0) begin
                $display("FAIL b2b_model: rdy=%0b rob=%0d val=%h full=%0b, required %0b %0d %h 0",
                         _cdb_ready, _cdb_rob_id, _cdb_value, _alu_full, exp_rdy, exp_id, exp_val);
                miscompares++;
            end
        end
        vectors++;
        if (pulses !== 10 || max_occ > 1) begin
            $display("FAIL b2b_count: pulses=%0d occupancy=%0d, required 10 and <=1", pulses, max_occ);
            miscompares++;
        end
    endtask

    task automatic test_clear();
        _stall = 1'b1;
        issue_rand(5'd4); tick();
        issue_rand(5'd5); tick();
        _clear = 1'b1; issue_rand(5'd6);
        tick();
        _clear = 1'b0; _stall = 1'b0; _alu_ready = 1'b0;
        vectors++;
        if (_cdb_ready !== 1'b0 || _alu_full !== 1'b0) begin
            $display("FAIL clear_state: rdy=%0b full=%0b, required 0 0", _cdb_ready, _alu_full); miscompares++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (_cdb_ready !== 1'b0) begin
                $display("FAIL clear_no_pulse[%0d]: rdy=%0b, required 0", i, _cdb_ready); miscompares++;
            end
        end
        issue(5'd0, 5'd7, 32'd1, 32'd2, 32'd0);
        tick();
        _alu_ready = 1'b0;
        tick();
        vectors++;
        if (_cdb_ready !== 1'b1 || _cdb_rob_id !== 5'd7 || _cdb_value !== 32'd3) begin
            $display("FAIL clear_resume: rdy=%0b rob=%0d val=%h, required 1 7 00000003",
                     _cdb_ready, _cdb_rob_id, _cdb_value);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_freeze_reset();
        issue_rand(5'd10); tick();
        issue_rand(5'd11); tick();
        rdy_in = 1'b0; _clear = 1'b1; _stall = 1'b1; issue_rand(5'd12);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (_cdb_ready !== 1'b1 || _cdb_rob_id !== 5'd10 || _cdb_value !== exp_val) begin
                $display("FAIL freeze[%0d]: rdy=%0b rob=%0d val=%h, required 1 10 %h",
                         i, _cdb_ready, _cdb_rob_id, _cdb_value, exp_val);
                miscompares++;
            end
        end
        rdy_in = 1'b1; _clear = 1'b0; _stall = 1'b0; _alu_ready = 1'b0;
        tick();
        vectors++;
        if (_cdb_ready !== 1'b1 || _cdb_rob_id !== 5'd11 || _cdb_value !== exp_val) begin
            $display("FAIL freeze_resume: rdy=%0b rob=%0d val=%h, required 1 11 %h",
                     _cdb_ready, _cdb_rob_id, _cdb_value, exp_val);
            miscompares++;
        end
        _stall = 1'b1;
        issue_rand(5'd13); tick();
        issue_rand(5'd14); tick();
        rst_in = 1'b0; issue_rand(5'd15);
        tick();
        vectors++;
        if (_cdb_ready !== 1'b0 || _cdb_rob_id !== 5'd0 || _cdb_value !== 32'd0 || _alu_full !== 1'b0) begin
            $display("FAIL mid_reset: rdy=%0b rob=%0d val=%h full=%0b, required all zero",
                     _cdb_ready, _cdb_rob_id, _cdb_value, _alu_full);
            miscompares++;
        end
        rst_in = 1'b1; _stall = 1'b0; _alu_ready = 1'b0;
        tick();
        vectors++;
        if (_cdb_ready !== 1'b0) begin
            $display("FAIL reset_empty: rdy=%0b, required 0", _cdb_ready); miscompares++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_in = ($urandom_range(99, 0) != 0);
            rdy_in = ($urandom_range(9, 0) != 0);
            _clear = ($urandom_range(19, 0) == 0);
            _stall = ($urandom_range(3, 0) == 0);
            if (!exp_full && $urandom_range(9, 0) < 7) issue_rand(5'($urandom_range(31, 0)));
            else _alu_ready = 1'b0;
            tick();
            vectors++;
            if (_cdb_ready !== exp_rdy || _cdb_rob_id !== exp_id || _cdb_value !== exp_val || _alu_full !== exp_full) begin
                $display("FAIL random[%0d]: rdy=%0b rob=%0d val=%h full=%0b, required %0b %0d %h %0b",
                         c, _cdb_ready, _cdb_rob_id, _cdb_value, _alu_full, exp_rdy, exp_id, exp_val, exp_full);
                miscompares++;
            end
        end
    endtask

    initial begin
        exp_rdy = 1'b0; exp_id = 5'd0; exp_val = 32'd0; exp_full = 1'b0;
        test_reset();
        test_add_latency();
        test_directed_ops();
        test_stall();
        test_back_to_back();
        test_clear();
        test_freeze_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer execution unit at the far end of the reservation station's ALU issue interface.
- Accepts one issued operation per cycle into a small in-order queue, back-pressures the station with _alu_full, and executes one op per cycle.
- Broadcasts each result on the ALU CDB lane (_cdb_ready/_cdb_rob_id/_cdb_value), which feeds the ROB and every reservation station.
- Flushed by _clear (mispredict); execution frozen by _stall.

Parameters:
DEPTH, 4, issue queue entries (power of two, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low (sampled on clk_in rising edge)
rdy_in  input  1  global ready; when low all state frozen
_clear  input  1  flush queue and in-flight result
_stall  input  1  hold execution; issue still accepted
_alu_ready  input  1  issue valid from reservation station
_alu_type  input  5  operation code (below)
_alu_rob_id  input  5  destination ROB tag
_alu_r1  input  32  operand A
_alu_r2  input  32  operand B (register form)
_alu_imm  input  32  immediate (I-form B operand / LUI value)
_alu_full  output  1  back-pressure to reservation station
_cdb_ready  output  1  result valid, one-cycle pulse per op
_cdb_rob_id  output  5  tag of broadcast result
_cdb_value  output  32  broadcast result

Behaviour:
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU (B=r2); 10 ADDI, 11 ANDI, 12 ORI, 13 XORI, 14 SLLI, 15 SRLI, 16 SRAI, 17 SLTI, 18 SLTIU (B=imm); 19 LUI (value=imm); 20 BEQ, 21 BNE, 22 BLT, 23 BGE, 24 BLTU, 25 BGEU (value=32'd1 if taken else 32'd0); 26-31 value=0, still broadcast.
- Arithmetic mod 2^32; shift amount = B[4:0]; SRA/SRAI/SLT/BLT/BGE signed, *U forms unsigned.
- Queue: circular FIFO, head/tail PTR_W bits wrapping modulo DEPTH, count 0..DEPTH.
- Issue accepted at edge when _alu_ready && count<DEPTH; entry stores type, rob_id, r1, r2, imm. Issue with count==DEPTH dropped (protocol violation; bench asserts never occurs).
- _alu_full = (count >= DEPTH-1), combinational from count; one-slot slack covers the station's registered issue.
- Execute: each edge with !_stall && count>0 pops head, computes, and registers _cdb_ready<=1, _cdb_rob_id, _cdb_value; otherwise _cdb_ready<=0 (rob_id/value hold last values).
- Latency: op issued at edge N into empty queue -> popped at edge N+1 -> _cdb_ready high for the cycle after N+1. Throughput 1 op/cycle, strict issue order.
- Simultaneous push and pop: count unchanged; push into full queue allowed when a pop occurs the same edge.
- Push into empty queue is not bypassed; it pops no earlier than the next edge.
- _stall high: no pop, _cdb_ready<=0, pushes continue until full.
- _clear high (priority over stall and issue): count, head, tail <=0; _cdb_ready<=0; same-cycle issue discarded.
- rdy_in low: no state or output change (incl. _cdb_ready held), issue ignored; _clear/_stall ignored.
- Priority at edge: reset > rdy_in low > _clear > normal.
- Reset (rst_in==0 at edge, also mid-operation): count/head/tail=0, _cdb_ready=0, _cdb_rob_id=0, _cdb_value=0; _alu_full=0 after reset.

Test Plan:
- Reset then ADD r1=5 r2=7 rob 3 -> _cdb_ready pulse 1 cycle, rob 3, value 12, two cycles after issue edge.
- SUB 0-1 -> 0xFFFFFFFF; SRA 0x80000000 by r2=0x21 -> 0xC0000000 (shamt 1); SLTU 1 vs 0xFFFFFFFF -> 1; SLT same operands -> 0; BGE -1 vs 0 -> 0.
- Hold _stall, issue 3 ops (rob 1,2,3) -> _alu_full high after 3rd, no CDB; release -> results rob 1,2,3 on consecutive cycles, _alu_full drops.
- Continuous issue every cycle for 10 ops with no stall -> 10 back-to-back pulses in order, count never exceeds 1, _alu_full never high.
- Queue holding 2 ops, assert _clear with concurrent issue -> no CDB pulse afterwards, _alu_full=0, next issued op broadcasts normally.
- rdy_in low for 3 cycles mid-stream, then rst_in low mid-stream -> state frozen during rdy_in low; after reset all outputs 0, queue empty.
